// File: rtl/nn_ctrl_pkg.sv
// rtl/nn_ctrl_pkg.sv - shared constants and state encoding for the inference sequencer
//
// Purpose: geometry of the feature image (784 bits carried as 25 x 32-bit words,
// the last word only partly used) and the sequencer state type.
// Ports: none (package).

package nn_ctrl_pkg;

  localparam int NUM_FEATURES   = 784;
  localparam int WORD_W         = 32;
  localparam int NUM_WORDS      = (NUM_FEATURES + WORD_W - 1) / WORD_W;
  localparam int LAST_WORD_BITS = NUM_FEATURES - WORD_W * (NUM_WORDS - 1);
  localparam int IDX_W          = 5;
  localparam int CLASS_W        = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    START,
    WAIT,
    RESULT,
    ERROR
  } state_e;

endpackage

// File: rtl/nn_feature_loader.sv
// rtl/nn_feature_loader.sv - word-write decode, feature image register and word mask
//
// Purpose: stores 32-bit feature words into the 784-bit image, tracks which
// words have been written since the last clear, and flags out-of-range indices.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en_i       an accepted word write this cycle
//   wr_idx_i      word index of the write
//   wr_data_i     word data; the last word keeps only its low LAST_WORD_BITS
//   mask_clr_i    clears the written-word mask (image contents are kept)
//   features_o    registered feature image
//   full_o        every word written since the last mask clear
//   idx_err_o     accepted write with an index beyond the last word (pulse)

module nn_feature_loader
  import nn_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [WORD_W-1:0]       wr_data_i,
  input  logic                    mask_clr_i,
  output logic [NUM_FEATURES-1:0] features_o,
  output logic                    full_o,
  output logic                    idx_err_o
);

  logic [NUM_FEATURES-1:0] feat_q;
  logic [NUM_FEATURES-1:0] feat_d;
  logic [NUM_WORDS-1:0]    mask_q;
  logic [NUM_WORDS-1:0]    mask_d;
  logic [NUM_WORDS-1:0]    wr_sel;
  logic                    idx_ok;

  assign idx_ok = (wr_idx_i < IDX_W'(NUM_WORDS));

  // One-hot word select; out-of-range writes select nothing and are dropped.
  always_comb begin
    wr_sel = '0;
    if (wr_en_i && idx_ok) begin
      wr_sel = NUM_WORDS'(1) << wr_idx_i;
    end
  end

  for (genvar w = 0; w < NUM_WORDS - 1; w++) begin : g_word
    assign feat_d[WORD_W*w +: WORD_W] = wr_sel[w] ? wr_data_i : feat_q[WORD_W*w +: WORD_W];
  end

  // The last word only carries the tail of the image; its upper bits are discarded.
  assign feat_d[NUM_FEATURES-1 -: LAST_WORD_BITS] =
    wr_sel[NUM_WORDS-1] ? wr_data_i[LAST_WORD_BITS-1:0]
                        : feat_q[NUM_FEATURES-1 -: LAST_WORD_BITS];

  assign mask_d = mask_clr_i ? '0 : (mask_q | wr_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_q <= '0;
      mask_q <= '0;
    end else begin
      feat_q <= feat_d;
      mask_q <= mask_d;
    end
  end

  assign features_o = feat_q;
  assign full_o     = &mask_q;
  assign idx_err_o  = wr_en_i && !idx_ok;

endmodule

// File: rtl/nn_inference_ctrl.sv
// rtl/nn_inference_ctrl.sv - run sequencer between the register file and the NeuralNetwork
//
// Purpose: loads the feature image, then per run clears the network, pulses
// start, waits for done (with a timeout), and returns the class via valid/ready.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_idx/wr_data   feature word write channel
//   cmd_valid/cmd_ready            start-inference request
//   res_valid/res_ready/res_class  prediction result
//   err_ack                        clears ERROR and sticky flags
//   busy, err_timeout, err_idx, run_count   status
//   nn_rst, nn_start, nn_features  to the network (registered)
//   nn_prediction, nn_done         from the network

module nn_inference_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [WORD_W-1:0]       wr_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CLASS_W-1:0]      res_class,
  input  logic                    err_ack,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_idx,
  output logic [CNT_W-1:0]        run_count,
  output logic                    nn_rst,
  output logic                    nn_start,
  output logic [NUM_FEATURES-1:0] nn_features,
  input  logic [CLASS_W-1:0]      nn_prediction,
  input  logic                    nn_done
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   run_count_q, run_count_d;
  logic [CLASS_W-1:0] res_class_q, res_class_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_idx_q, err_idx_d;
  logic               nn_rst_q, nn_rst_d;
  logic               nn_start_q, nn_start_d;

  logic wr_accept;
  logic cmd_accept;
  logic mask_clr;
  logic full;
  logic idx_err;

  assign wr_ready   = (state_q == IDLE) || (state_q == LOAD);
  assign wr_accept  = wr_valid && wr_ready;
  // Uses the registered mask, so a final write enables cmd_ready one cycle later.
  assign cmd_ready  = wr_ready && full;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign res_valid  = (state_q == RESULT);
  assign busy       = (state_q == CLEAR) || (state_q == START) ||
                      (state_q == WAIT)  || (state_q == RESULT);
  assign mask_clr   = (res_valid && res_ready) || (state_q == ERROR);

  nn_feature_loader u_loader (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_accept),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (wr_data),
    .mask_clr_i (mask_clr),
    .features_o (nn_features),
    .full_o     (full),
    .idx_err_o  (idx_err)
  );

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    run_count_d   = run_count_q;
    res_class_d   = res_class_q;
    err_timeout_d = err_timeout_q;
    err_idx_d     = err_idx_q;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          state_d = CLEAR;
        end else if (wr_accept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cmd_accept) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = START;
      end
      START: begin
        state_d   = WAIT;
        tmo_cnt_d = '0;
      end
      WAIT: begin
        if (nn_done) begin
          res_class_d = nn_prediction;
          state_d     = RESULT;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ERROR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          run_count_d = run_count_q + 1'b1;
          state_d     = IDLE;
        end
      end
      ERROR: begin
        if (err_ack) begin
          err_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A bad index arriving together with the acknowledge stays flagged.
    if (err_ack) begin
      err_idx_d = 1'b0;
    end
    if (idx_err) begin
      err_idx_d = 1'b1;
    end

    // Network controls follow the state being entered, so they line up with it.
    // Holding nn_rst outside the run keeps a stale nn_done out of WAIT.
    nn_rst_d   = (state_d == IDLE) || (state_d == LOAD) ||
                 (state_d == CLEAR) || (state_d == ERROR);
    nn_start_d = (state_d == START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      run_count_q   <= '0;
      res_class_q   <= '0;
      err_timeout_q <= 1'b0;
      err_idx_q     <= 1'b0;
      nn_rst_q      <= 1'b1;
      nn_start_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      run_count_q   <= run_count_d;
      res_class_q   <= res_class_d;
      err_timeout_q <= err_timeout_d;
      err_idx_q     <= err_idx_d;
      nn_rst_q      <= nn_rst_d;
      nn_start_q    <= nn_start_d;
    end
  end

  assign res_class   = res_class_q;
  assign run_count   = run_count_q;
  assign err_timeout = err_timeout_q;
  assign err_idx     = err_idx_q;
  assign nn_rst      = nn_rst_q;
  assign nn_start    = nn_start_q;

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// tb/tb_nn_inference_ctrl.sv - self-checking bench for nn_inference_ctrl

module tb_nn_inference_ctrl;

  localparam int TMO = 64;
  localparam int NW  = 25;
  localparam int NF  = 784;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_idx;
  logic [31:0]   wr_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          res_valid;
  logic          res_ready;
  logic [3:0]    res_class;
  logic          err_ack;
  logic          busy;
  logic          err_timeout;
  logic          err_idx;
  logic [15:0]   run_count;
  logic          nn_rst;
  logic          nn_start;
  logic [NF-1:0] nn_features;
  logic [3:0]    nn_prediction;
  logic          nn_done;

  nn_inference_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_class     (res_class),
    .err_ack       (err_ack),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .err_idx       (err_idx),
    .run_count     (run_count),
    .nn_rst        (nn_rst),
    .nn_start      (nn_start),
    .nn_features   (nn_features),
    .nn_prediction (nn_prediction),
    .nn_done       (nn_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: image words, written-word set, completed runs.
  logic [31:0] words [NW];
  bit          mask_m [NW];
  int          runs_m = 0;

  // Network stub, acting on the falling edge to stay clear of the DUT edge.
  int          stub_delay = 5;
  logic [3:0]  stub_pred  = 4'd0;
  bit          stub_never = 1'b0;
  bit          stub_armed;
  int          stub_cnt;
  int          start_pulses = 0;

  always @(negedge clk) begin
    if (nn_start === 1'b1) start_pulses++;
    if (nn_rst !== 1'b0) begin
      nn_done       = 1'b0;
      nn_prediction = 4'd0;
      stub_armed    = 1'b0;
      stub_cnt      = 0;
    end else if (nn_start) begin
      stub_armed = 1'b1;
      stub_cnt   = 0;
    end else if (stub_armed && !stub_never && !nn_done) begin
      stub_cnt++;
      if (stub_cnt == stub_delay) begin
        nn_done       = 1'b1;
        nn_prediction = stub_pred;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time limit, expected $finish");
    $fatal(1);
  end

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [NF-1:0] obs, input logic [NF-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit b of the image is bit (b mod 32) of word (b / 32); bits past 783 do not exist.
  function automatic logic [NF-1:0] model_features();
    logic [NF-1:0] f;
    logic [31:0]   wv;
    for (int b = 0; b < NF; b++) begin
      wv = words[5'(b / 32)];
      f[10'(b)] = wv[5'(b % 32)];
    end
    return f;
  endfunction

  function automatic bit model_full();
    bit all = 1'b1;
    for (int i = 0; i < NW; i++) all &= mask_m[5'(i)];
    return all;
  endfunction

  task automatic model_clear_mask();
    for (int i = 0; i < NW; i++) mask_m[5'(i)] = 1'b0;
  endtask

  task automatic write_word(input int idx, input logic [31:0] data);
    wr_valid = 1'b1;
    wr_idx   = 5'(idx);
    wr_data  = data;
    check_b("wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    if (idx < NW) begin
      words[5'(idx)]  = data;
      mask_m[5'(idx)] = 1'b1;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NW; i++) write_word(i, $urandom());
  endtask

  task automatic do_run(input logic [3:0] pred, input int delay, input int hold);
    logic [NF-1:0] exp_f;
    bit            feat_bad;
    int            n;
    int            st0;
    exp_f      = model_features();
    feat_bad   = 1'b0;
    stub_pred  = pred;
    stub_delay = delay;
    stub_never = 1'b0;
    st0        = start_pulses;
    cmd_valid  = 1'b1;
    check_b("cmd_ready_full", cmd_ready, model_full());
    tick();
    cmd_valid = 1'b0;
    check_b("clear_busy", busy, 1'b1);
    check_b("clear_wr_ready", wr_ready, 1'b0);
    check_b("clear_nn_rst", nn_rst, 1'b1);
    check_b("clear_nn_start", nn_start, 1'b0);
    tick();
    check_b("start_nn_start", nn_start, 1'b1);
    check_b("start_nn_rst", nn_rst, 1'b0);
    check_v("features_at_start", nn_features, exp_f);
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
      if (nn_features !== exp_f) feat_bad = 1'b1;
      if (nn_start !== 1'b0) feat_bad = 1'b1;
    end
    check_v("done_latency", NF'(n), NF'(delay + 1));
    check_v("start_pulses", NF'(start_pulses - st0), NF'(1));
    for (int h = 0; h < hold; h++) begin
      check_b("res_hold_valid", res_valid, 1'b1);
      check_v("res_hold_class", NF'(res_class), NF'(pred));
      tick();
      if (nn_features !== exp_f) feat_bad = 1'b1;
    end
    check_b("res_valid", res_valid, 1'b1);
    check_v("res_class", NF'(res_class), NF'(pred));
    check_b("features_stable", feat_bad, 1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    runs_m++;
    model_clear_mask();
    check_b("res_consumed", res_valid, 1'b0);
    check_v("run_count", NF'(run_count), NF'(16'(runs_m)));
    check_b("post_nn_rst", nn_rst, 1'b1);
    check_b("post_cmd_ready", cmd_ready, 1'b0);
    check_b("post_busy", busy, 1'b0);
  endtask

  initial begin
    int            n;
    logic [NF-1:0] ones;
    logic [31:0]   w24;
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_idx    = 5'd0;
    wr_data   = 32'd0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    err_ack   = 1'b0;
    for (int i = 0; i < NW; i++) words[5'(i)] = 32'd0;
    model_clear_mask();
    tick();
    tick();
    #3 rst = 1'b0;
    tick();

    // Reset state
    check_b("rst_nn_rst", nn_rst, 1'b1);
    check_b("rst_nn_start", nn_start, 1'b0);
    check_b("rst_res_valid", res_valid, 1'b0);
    check_v("rst_res_class", NF'(res_class), NF'(0));
    check_v("rst_run_count", NF'(run_count), NF'(0));
    check_b("rst_err_timeout", err_timeout, 1'b0);
    check_b("rst_err_idx", err_idx, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_v("rst_features", nn_features, '0);
    check_b("rst_wr_ready", wr_ready, 1'b1);
    check_b("rst_cmd_ready", cmd_ready, 1'b0);

    // All-ones image, stub answers 7 after 5 cycles, result held 3 cycles
    for (int i = 0; i < NW; i++) write_word(i, 32'hFFFF_FFFF);
    ones = '1;
    check_v("all_ones", nn_features, ones);
    do_run(4'd7, 5, 3);

    // Partial load: cmd held, not accepted until word 24 lands
    for (int i = 0; i < NW - 1; i++) write_word(i, $urandom());
    write_word(5, $urandom());
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_b("partial_cmd_ready", cmd_ready, 1'b0);
      tick();
      check_b("partial_busy", busy, 1'b0);
    end
    w24 = $urandom() | 32'h8000_0000;
    check_b("final_write_cmd_ready", cmd_ready, 1'b0);
    write_word(24, w24);
    check_b("final_write_busy", busy, 1'b0);
    check_b("cmd_ready_next", cmd_ready, 1'b1);
    check_v("word24_low_bits", NF'(nn_features[NF-1 -: 16]), NF'(w24[15:0]));
    check_v("features_model", nn_features, model_features());
    do_run(4'($urandom_range(0, 9)), $urandom_range(1, 10), $urandom_range(0, 3));

    // Out-of-range index: dropped, flagged, mask untouched
    for (int i = 0; i < NW - 1; i++) write_word(i, $urandom());
    write_word(26, $urandom());
    check_b("err_idx_set", err_idx, 1'b1);
    check_b("err_idx_mask", cmd_ready, 1'b0);
    check_v("err_idx_features", nn_features, model_features());
    write_word(25, $urandom());
    check_b("err_idx_mask25", cmd_ready, 1'b0);
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
    check_b("err_idx_cleared", err_idx, 1'b0);
    check_b("err_ack_still_load", wr_ready, 1'b1);
    write_word(24, $urandom());
    check_b("err_idx_full", cmd_ready, 1'b1);
    do_run(4'($urandom_range(0, 9)), $urandom_range(1, 10), $urandom_range(0, 3));

    // Back-to-back random runs
    for (int r = 0; r < 3; r++) begin
      load_random();
      do_run(4'($urandom_range(0, 9)), $urandom_range(1, 12), $urandom_range(0, 4));
    end

    // Timeout: stub never finishes
    load_random();
    stub_never = 1'b1;
    cmd_valid  = 1'b1;
    check_b("tmo_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    check_b("tmo_nn_start", nn_start, 1'b1);
    n = 0;
    while (!err_timeout && n < 300) begin
      tick();
      n++;
    end
    check_v("tmo_latency", NF'(n), NF'(TMO + 1));
    check_b("tmo_nn_rst", nn_rst, 1'b1);
    check_b("tmo_busy", busy, 1'b0);
    check_b("tmo_wr_ready", wr_ready, 1'b0);
    check_b("tmo_res_valid", res_valid, 1'b0);
    tick();
    tick();
    check_b("tmo_sticky", err_timeout, 1'b1);
    check_b("tmo_cmd_ready", cmd_ready, 1'b0);
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
    model_clear_mask();
    check_b("tmo_cleared", err_timeout, 1'b0);
    check_b("tmo_idle_wr_ready", wr_ready, 1'b1);
    check_b("tmo_mask_clear", cmd_ready, model_full());
    check_v("tmo_run_count", NF'(run_count), NF'(16'(runs_m)));
    stub_never = 1'b0;

    // Asynchronous reset in WAIT, then a full reload and run
    load_random();
    stub_delay = 30;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_b("arst_in_wait_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_b("arst_nn_rst", nn_rst, 1'b1);
    check_b("arst_res_valid", res_valid, 1'b0);
    check_b("arst_busy", busy, 1'b0);
    check_v("arst_features", nn_features, '0);
    check_v("arst_run_count", NF'(run_count), NF'(0));
    #1 rst = 1'b0;
    runs_m = 0;
    for (int i = 0; i < NW; i++) words[5'(i)] = 32'd0;
    model_clear_mask();
    tick();
    check_b("arst_cmd_ready", cmd_ready, 1'b0);
    load_random();
    do_run(4'($urandom_range(0, 9)), $urandom_range(1, 10), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
